vec_issue_ctrl: RTL and testbench

//  In-order issue controller between the vector instruction FIFO and the vector dispatch decoder.

---
 rtl/vec_issue_ctrl_if.sv | 27 ++
 rtl/vec_issue_ctrl.sv | 158 +++++++++++++++
 tb/tb_vec_issue_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vec_issue_ctrl_if.sv
// Handshake between the vector instruction FIFO / dispatch decoder and the issue controller.
// master = FIFO/decoder side, slave = issue controller.
interface vec_issue_ctrl_if #(
    parameter int INSTRUCTION_BITS = 32
);
    logic                        fifo_valid;
    logic [INSTRUCTION_BITS-1:0] fifo_instr;
    logic                        fifo_pop;
    logic                        issue_valid;
    logic                        dec_ready;

    modport master (
        output fifo_valid,
        output fifo_instr,
        output dec_ready,
        input  fifo_pop,
        input  issue_valid
    );

    modport slave (
        input  fifo_valid,
        input  fifo_instr,
        input  dec_ready,
        output fifo_pop,
        output issue_valid
    );
endinterface

// File: rtl/vec_issue_ctrl.sv
// In-order vector issue controller: per-register scoreboard (RAW/WAW), single memory unit
// tracking, and a drain (fence) handshake in front of the dispatch decoder.
module vec_issue_ctrl #(
    parameter int INSTRUCTION_BITS = 32,
    parameter int ALU_LATENCY      = 2,
    parameter int MUL_LATENCY      = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    vec_issue_ctrl_if.slave        bus,
    input  logic                   mem_done,
    input  logic                   drain_req,
    output logic                   drained,
    output logic                   mem_busy,
    output logic [31:0]            pending_vregs,
    output logic [1:0]             stall_cause
);
    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [3:0] ALU_CNT = 4'(ALU_LATENCY);
    localparam logic [3:0] MUL_CNT = 4'(MUL_LATENCY);

    state_t      state_q, state_d;
    logic        mem_busy_q, mem_busy_d;

    logic [31:0] instr;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [5:0]  f6;
    logic        vm;
    logic [4:0]  vd, vs1, vs2;
    logic        is_arith, is_load, is_store, is_mem;
    logic        rd_vs2, rd_vs1, rd_vd, rd_v0, wr_vd, long_lat;
    logic        hazard, mem_stall, issue_valid_int, pop;
    logic        arith_pop, load_pop, mem_pop, mem_done_eff;
    logic [3:0]  lat_cnt;

    assign instr = bus.fifo_instr[31:0];
    assign op    = instr[6:0];
    assign vd    = instr[11:7];
    assign f3    = instr[14:12];
    assign vs1   = instr[19:15];
    assign vs2   = instr[24:20];
    assign vm    = instr[25];
    assign f6    = instr[31:26];

    always_comb begin
        is_arith = (op == 7'b1010111);
        is_load  = (op == 7'b0000111);
        is_store = (op == 7'b0100111);
        is_mem   = is_load | is_store;
        // Memory ops only index through vs2 for the indexed addressing modes (mop[0]=1).
        rd_vs2   = is_arith | (is_mem & instr[26]);
        rd_vs1   = is_arith & (f3 inside {3'b000, 3'b001, 3'b010});
        rd_vd    = is_store
                 | (is_arith & (f3 inside {3'b010, 3'b110}) & (f6 inside {6'b101101, 6'b101001}));
        rd_v0    = ((is_arith | is_mem) & ~vm)
                 | (is_arith & (f3 inside {3'b000, 3'b011, 3'b100}) & (f6 == 6'b010000));
        wr_vd    = is_arith | is_load;
        long_lat = is_arith & ((f3 inside {3'b001, 3'b101})
                 | ((f3 inside {3'b010, 3'b110})
                    & (f6 inside {6'b100100, 6'b100101, 6'b100110, 6'b100111, 6'b101001, 6'b101101})));
        lat_cnt  = long_lat ? MUL_CNT : ALU_CNT;
    end

    // No bypass: a source stays blocked until its counter has fully reached zero.
    assign hazard = (rd_vs2 & pending_vregs[vs2])
                  | (rd_vs1 & pending_vregs[vs1])
                  | ((rd_vd | wr_vd) & pending_vregs[vd])
                  | (rd_v0 & pending_vregs[0]);

    assign mem_stall       = is_mem & mem_busy_q;
    assign issue_valid_int = (state_q == ST_RUN) & bus.fifo_valid & ~drain_req & ~hazard & ~mem_stall;
    assign pop             = issue_valid_int & bus.dec_ready;
    assign arith_pop       = pop & is_arith;
    assign load_pop        = pop & is_load;
    assign mem_pop         = pop & is_mem;
    assign mem_done_eff    = mem_done & mem_busy_q;

    assign bus.issue_valid = issue_valid_int;
    assign bus.fifo_pop    = pop;
    assign mem_busy        = mem_busy_q;

    for (genvar gi = 0; gi < 32; gi++) begin : g_sb
        logic [3:0] cnt_q, cnt_d;
        logic       ld_pend_q, ld_pend_d;

        always_comb begin
            cnt_d     = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
            ld_pend_d = ld_pend_q & ~mem_done_eff;
            if (arith_pop && (vd == 5'(gi))) begin
                cnt_d = lat_cnt;
            end
            if (load_pop && (vd == 5'(gi))) begin
                ld_pend_d = 1'b1;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q     <= 4'd0;
                ld_pend_q <= 1'b0;
            end else begin
                cnt_q     <= cnt_d;
                ld_pend_q <= ld_pend_d;
            end
        end

        assign pending_vregs[gi] = (cnt_q != 4'd0) | ld_pend_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:  state_d = ST_RUN;
            ST_RUN:   if (drain_req)  state_d = ST_DRAIN;
            ST_DRAIN: if (!drain_req) state_d = ST_RUN;
            default:  state_d = ST_INIT;
        endcase
    end

    always_comb begin
        mem_busy_d = mem_busy_q;
        if (mem_done_eff) begin
            mem_busy_d = 1'b0;
        end
        if (mem_pop) begin
            mem_busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            mem_busy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_busy_q <= mem_busy_d;
        end
    end

    assign drained = (state_q == ST_DRAIN) & (pending_vregs == 32'd0) & ~mem_busy_q;

    always_comb begin
        stall_cause = 2'd0;
        if ((state_q != ST_RUN) || drain_req) begin
            stall_cause = 2'd3;
        end else if (bus.fifo_valid && hazard) begin
            stall_cause = 2'd1;
        end else if (bus.fifo_valid && mem_stall) begin
            stall_cause = 2'd2;
        end
    end
endmodule

// File: tb/tb_vec_issue_ctrl.sv
// Directed bench for vec_issue_ctrl: a cycle-numbered scoreboard model checked every cycle,
// plus hand-computed issue gaps and status values for each scenario.
module tb_vec_issue_ctrl;
    localparam int ALU_L = 2;
    localparam int MUL_L = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_done = 1'b0;
    logic        drain_req = 1'b0;
    logic        drained, mem_busy;
    logic [31:0] pending_vregs;
    logic [1:0]  stall_cause;

    vec_issue_ctrl_if #(.INSTRUCTION_BITS(32)) bus ();

    vec_issue_ctrl #(
        .INSTRUCTION_BITS(32),
        .ALU_LATENCY(ALU_L),
        .MUL_LATENCY(MUL_L)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave),
        .mem_done(mem_done),
        .drain_req(drain_req),
        .drained(drained),
        .mem_busy(mem_busy),
        .pending_vregs(pending_vregs),
        .stall_cause(stall_cause)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [31:0] q[$];
    int          pop_cyc[$];
    int          haz_cnt = 0;
    int          mem_cnt = 0;

    // Model state: a register is busy while the cycle number is below free_at, or while a load to it is open.
    int          free_at[32];
    logic [31:0] ld_set;
    bit          m_busy;
    int          m_st;   // 0 init, 1 run, 2 drain

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] enc_arith(input logic [5:0] f6, input logic vm, input logic [4:0] vs2,
                                              input logic [4:0] vs1, input logic [2:0] f3, input logic [4:0] vd);
        return {f6, vm, vs2, vs1, f3, vd, 7'b1010111};
    endfunction

    function automatic logic [31:0] enc_mem(input logic st, input logic vm, input logic [4:0] vs2, input logic [4:0] vd);
        return {6'b000000, vm, vs2, 5'd0, 3'b111, vd, (st ? 7'b0100111 : 7'b0000111)};
    endfunction

    function automatic logic [31:0] add(input logic [4:0] vd, input logic [4:0] vs1, input logic vm);
        return enc_arith(6'b000000, vm, 5'd2, vs1, 3'b000, vd);
    endfunction

    // kind: 0 other, 1 arith, 2 load, 3 store
    function automatic void mdecode(input logic [31:0] i, output logic [31:0] rmask, output logic [31:0] wmask,
                                    output int kind, output int lat);
        logic [2:0] f3;
        logic [5:0] f6;
        f3 = i[14:12];
        f6 = i[31:26];
        rmask = 32'd0;
        wmask = 32'd0;
        kind = 0;
        lat = ALU_L;
        if (i[6:0] == 7'b1010111) begin
            kind = 1;
            rmask[i[24:20]] = 1'b1;
            if (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010) rmask[i[19:15]] = 1'b1;
            if ((f3 == 3'b010 || f3 == 3'b110) && (f6 == 6'b101101 || f6 == 6'b101001)) rmask[i[11:7]] = 1'b1;
            if (!i[25]) rmask[0] = 1'b1;
            if ((f3 == 3'b000 || f3 == 3'b011 || f3 == 3'b100) && f6 == 6'b010000) rmask[0] = 1'b1;
            wmask[i[11:7]] = 1'b1;
            if (f3 == 3'b001 || f3 == 3'b101) lat = MUL_L;
            if ((f3 == 3'b010 || f3 == 3'b110) && f6 >= 6'b100100 && f6 <= 6'b100111) lat = MUL_L;
            if ((f3 == 3'b010 || f3 == 3'b110) && (f6 == 6'b101001 || f6 == 6'b101101)) lat = MUL_L;
        end else if (i[6:0] == 7'b0000111 || i[6:0] == 7'b0100111) begin
            kind = (i[6:0] == 7'b0000111) ? 2 : 3;
            if (i[26]) rmask[i[24:20]] = 1'b1;
            if (!i[25]) rmask[0] = 1'b1;
            if (kind == 2) wmask[i[11:7]] = 1'b1;
            else           rmask[i[11:7]] = 1'b1;
        end
    endfunction

    task automatic model_reset();
        foreach (free_at[r]) free_at[r] = 0;
        ld_set = 32'd0;
        m_busy = 1'b0;
        m_st   = 0;
    endtask

    // Compare process: evaluate expectations mid-cycle, advance the model on the rising edge.
    initial begin : model
        logic [31:0] pmask, rmask, wmask;
        int          kind, lat;
        bit          haz, mstall, e_iv, e_pop, e_drn, s_pop, s_md, s_dr;
        logic [1:0]  e_sc;
        logic [31:0] s_instr;
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) model_reset();
            for (int r = 0; r < 32; r++) pmask[r] = (cyc < free_at[r]) || ld_set[r];
            mdecode(bus.fifo_instr, rmask, wmask, kind, lat);
            haz    = ((rmask | wmask) & pmask) != 32'd0;
            mstall = (kind >= 2) && m_busy;
            e_iv   = (m_st == 1) && bus.fifo_valid && !drain_req && !haz && !mstall;
            e_pop  = e_iv && bus.dec_ready;
            e_drn  = (m_st == 2) && (pmask == 32'd0) && !m_busy;
            if (m_st != 1 || drain_req)        e_sc = 2'd3;
            else if (bus.fifo_valid && haz)    e_sc = 2'd1;
            else if (bus.fifo_valid && mstall) e_sc = 2'd2;
            else                               e_sc = 2'd0;
            chk("issue_valid", 32'(bus.issue_valid), 32'(e_iv));
            chk("fifo_pop", 32'(bus.fifo_pop), 32'(e_pop));
            chk("stall_cause", 32'(stall_cause), 32'(e_sc));
            chk("pending_vregs", pending_vregs, pmask);
            chk("mem_busy", 32'(mem_busy), 32'(m_busy));
            chk("drained", 32'(drained), 32'(e_drn));
            s_pop = e_pop; s_instr = bus.fifo_instr; s_md = mem_done; s_dr = drain_req;
            @(posedge clk);
            if (!rst_n) begin
                model_reset();
            end else begin
                if (s_md && m_busy) begin
                    m_busy = 1'b0;
                    ld_set = 32'd0;
                end
                if (s_pop) begin
                    mdecode(s_instr, rmask, wmask, kind, lat);
                    if (kind == 1) free_at[s_instr[11:7]] = cyc + lat + 1;
                    if (kind == 2) ld_set[s_instr[11:7]] = 1'b1;
                    if (kind >= 2) m_busy = 1'b1;
                end
                if (m_st == 0)                   m_st = 1;
                else if (m_st == 1 && s_dr)      m_st = 2;
                else if (m_st == 2 && !s_dr)     m_st = 1;
            end
            cyc++;
        end
    end

    // FIFO head driver: presents the queue head and retires it after each accepted pop.
    initial begin : driver
        bit pop_now;
        bus.fifo_valid = 1'b0;
        bus.fifo_instr = 32'd0;
        bus.dec_ready  = 1'b1;
        forever begin
            @(negedge clk);
            pop_now = bus.fifo_pop;
            if (stall_cause == 2'd1) haz_cnt++;
            if (stall_cause == 2'd2) mem_cnt++;
            if (pop_now) begin
                pop_cyc.push_back(cyc);
                $display("issue cyc=%0d instr=%08h", cyc, bus.fifo_instr);
            end
            @(posedge clk);
            #1;
            if (pop_now && q.size() > 0) void'(q.pop_front());
            bus.fifo_valid = (q.size() > 0);
            bus.fifo_instr = (q.size() > 0) ? q[0] : 32'd0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pops(input int n);
        int k = 0;
        while (pop_cyc.size() < n && k < 60) begin
            tick();
            k++;
        end
        chk("pop_count", 32'(pop_cyc.size()), 32'(n));
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((pending_vregs != 32'd0 || mem_busy) && k < 30) begin
            tick();
            k++;
        end
        chk("idle_pending", pending_vregs, 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int b, k, md;
        #2;
        chk("rst_issue_valid", 32'(bus.issue_valid), 32'd0);
        chk("rst_stall_cause", 32'(stall_cause), 32'd3);
        chk("rst_pending", pending_vregs, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // 1: ADD v3 then a reader of v3
        b = pop_cyc.size(); haz_cnt = 0;
        q.push_back(add(5'd3, 5'd1, 1'b1));
        q.push_back(add(5'd7, 5'd3, 1'b1));
        wait_pops(b + 1);
        #2;
        chk("t1_pending_v3", 32'(pending_vregs[3]), 32'd1);
        chk("t1_stall_haz", 32'(stall_cause), 32'd1);
        wait_pops(b + 2);
        chk("t1_gap", 32'(pop_cyc[b + 1] - pop_cyc[b]), 32'd3);
        chk("t1_haz_cycles", 32'(haz_cnt), 32'd2);
        wait_idle();

        // 2: vmul v5, independent ADD v6, then reader of v5
        b = pop_cyc.size(); haz_cnt = 0;
        q.push_back(enc_arith(6'b100101, 1'b1, 5'd2, 5'd1, 3'b010, 5'd5));
        q.push_back(add(5'd6, 5'd1, 1'b1));
        q.push_back(add(5'd9, 5'd5, 1'b1));
        wait_pops(b + 3);
        chk("t2_indep_gap", 32'(pop_cyc[b + 1] - pop_cyc[b]), 32'd1);
        chk("t2_mul_gap", 32'(pop_cyc[b + 2] - pop_cyc[b]), 32'd5);
        chk("t2_haz_cycles", 32'(haz_cnt), 32'd3);
        wait_idle();

        // 3: LOAD v8 then STORE v10 waits for the memory unit
        b = pop_cyc.size(); mem_cnt = 0;
        q.push_back(enc_mem(1'b0, 1'b1, 5'd0, 5'd8));
        q.push_back(enc_mem(1'b1, 1'b1, 5'd0, 5'd10));
        wait_pops(b + 1);
        tick(); tick(); tick();
        mem_done = 1'b1; md = cyc;
        tick();
        mem_done = 1'b0;
        wait_pops(b + 2);
        chk("t3_store_after_done", 32'(pop_cyc[b + 1]), 32'(md + 1));
        chk("t3_mem_stall_cycles", 32'(mem_cnt), 32'd4);
        #2;
        chk("t3_v8_cleared", 32'(pending_vregs[8]), 32'd0);
        chk("t3_store_busy", 32'(mem_busy), 32'd1);
        mem_done = 1'b1;
        tick();
        mem_done = 1'b1;   // second pulse lands while idle and must be ignored
        tick();
        mem_done = 1'b0;
        chk("t3_idle_after_done", 32'(mem_busy), 32'd0);
        wait_idle();

        // 4: v0 mask dependencies
        b = pop_cyc.size();
        q.push_back(add(5'd0, 5'd1, 1'b1));
        q.push_back(add(5'd11, 5'd1, 1'b0));
        wait_pops(b + 2);
        chk("t4_masked_gap", 32'(pop_cyc[b + 1] - pop_cyc[b]), 32'd3);
        wait_idle();
        b = pop_cyc.size();
        q.push_back(add(5'd0, 5'd1, 1'b1));
        q.push_back(add(5'd11, 5'd1, 1'b1));
        wait_pops(b + 2);
        chk("t4_unmasked_gap", 32'(pop_cyc[b + 1] - pop_cyc[b]), 32'd1);
        wait_idle();
        b = pop_cyc.size();
        q.push_back(add(5'd0, 5'd1, 1'b1));
        q.push_back(enc_arith(6'b010000, 1'b0, 5'd2, 5'd1, 3'b000, 5'd12));
        wait_pops(b + 2);
        chk("t4_vadc_gap", 32'(pop_cyc[b + 1] - pop_cyc[b]), 32'd3);
        wait_idle();

        // 5: decoder backpressure, then drain with v2 pending
        b = pop_cyc.size();
        bus.dec_ready = 1'b0;
        q.push_back(add(5'd2, 5'd1, 1'b1));
        tick(); tick();
        #2;
        chk("t5_valid_held", 32'(bus.issue_valid), 32'd1);
        chk("t5_no_pop", 32'(bus.fifo_pop), 32'd0);
        chk("t5_sb_unchanged", pending_vregs, 32'd0);
        bus.dec_ready = 1'b1;
        wait_pops(b + 1);
        drain_req = 1'b1;
        q.push_back(add(5'd14, 5'd1, 1'b1));
        k = 0;
        #1;
        while (!drained && k < 10) begin
            tick();
            #1;
            k++;
        end
        chk("t5_drain_wait", 32'(k), 32'd2);
        chk("t5_drained_pending", pending_vregs, 32'd0);
        chk("t5_no_issue_in_drain", 32'(pop_cyc.size()), 32'(b + 1));
        tick();
        drain_req = 1'b0;
        wait_pops(b + 2);
        wait_idle();

        // 6: reset while v4 and the memory unit are busy
        b = pop_cyc.size();
        q.push_back(enc_mem(1'b0, 1'b1, 5'd0, 5'd13));
        q.push_back(add(5'd4, 5'd1, 1'b1));
        wait_pops(b + 2);
        #2;
        chk("t6_v4_pending", 32'(pending_vregs[4]), 32'd1);
        chk("t6_busy", 32'(mem_busy), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_pending", pending_vregs, 32'd0);
        chk("t6_rst_busy", 32'(mem_busy), 32'd0);
        chk("t6_rst_stall", 32'(stall_cause), 32'd3);
        q.push_back(add(5'd1, 5'd2, 1'b1));
        tick();
        rst_n = 1'b1;
        mem_done = 1'b1;
        #2;
        chk("t6_init_no_issue", 32'(bus.issue_valid), 32'd0);
        chk("t6_init_stall", 32'(stall_cause), 32'd3);
        tick();
        mem_done = 1'b0;
        #2;
        chk("t6_run_issue", 32'(bus.issue_valid), 32'd1);
        chk("t6_done_ignored", 32'(mem_busy), 32'd0);
        wait_pops(b + 3);
        wait_idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
